// File: rtl/ascii_disp_pkg.sv
// Shared types and constants for the ASCII scroller and its
// display-side neighbours.
package ascii_disp_pkg;

    localparam logic [7:0] ASCII_SPACE    = 8'h20;
    localparam int         NUM_DIGITS_DEF = 6;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SCROLL
    } scroll_state_t;

endpackage

// File: rtl/ascii_msg_buffer.sv
// Message storage: one write port, NUM_DIGITS combinational
// read ports (one per display digit).
module ascii_msg_buffer #(
    parameter int MSG_DEPTH  = 32,
    parameter int NUM_DIGITS = 6,
    parameter int AW         = $clog2(MSG_DEPTH)
) (
    input  logic                         clk,
    input  logic                         we_i,
    input  logic [AW-1:0]                waddr_i,
    input  logic [7:0]                   wdata_i,
    input  logic [NUM_DIGITS-1:0][AW-1:0] raddr_i,
    output logic [NUM_DIGITS-1:0][7:0]   rdata_o
);

    // No reset: contents are don't-care until written.
    logic [7:0] mem_q [MSG_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            rdata_o[d] = mem_q[raddr_i[d]];
        end
    end

endmodule

// File: rtl/ascii_scroller.sv
// Message loader and right-to-left scroll sequencer for ASCII digits.
// Define ASCII_SCROLLER_HOLD_EN to add the hold (pause) input.
module ascii_scroller
    import ascii_disp_pkg::*;
#(
    parameter int NUM_DIGITS = NUM_DIGITS_DEF,
    parameter int MSG_DEPTH  = 32,
    parameter int TICK_DIV   = 25_000_000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_char,
    input  logic                          wr_last,
    input  logic                          clear,
`ifdef ASCII_SCROLLER_HOLD_EN
    input  logic                          hold,
`endif
    output logic [8*NUM_DIGITS-1:0]       ascii_out,
    output logic [$clog2(MSG_DEPTH+1)-1:0] msg_len,
    output logic                          scrolling
);

    localparam int LW = $clog2(MSG_DEPTH + 1);
    localparam int AW = $clog2(MSG_DEPTH);
    localparam int VW = $clog2(MSG_DEPTH + 2 * NUM_DIGITS);
    localparam int TW = $clog2(TICK_DIV);

    scroll_state_t           state_q, state_d;
    logic [LW-1:0]           len_q, len_d;
    logic [VW-1:0]           off_q, off_d;
    logic [TW-1:0]           tick_q, tick_d;
    logic [8*NUM_DIGITS-1:0] ascii_q, ascii_d;

    logic                         accept;
    logic                         commit;
    logic                         run;
    logic                         last_tick;
    logic [VW-1:0]                plen;
    logic [VW-1:0]                vsum [NUM_DIGITS];
    logic [VW-1:0]                vidx [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]        blank;
    logic [NUM_DIGITS-1:0][AW-1:0] raddr;
    logic [NUM_DIGITS-1:0][7:0]   rdata;

`ifdef ASCII_SCROLLER_HOLD_EN
    assign run = !hold;
`else
    assign run = 1'b1;
`endif

    assign wr_ready  = !clear && (state_q != SCROLL)
                       && (len_q < LW'(MSG_DEPTH));
    assign accept    = wr_valid && wr_ready;
    assign commit    = wr_last || (len_q == LW'(MSG_DEPTH - 1));
    assign last_tick = (tick_q == TW'(TICK_DIV - 1));
    assign plen      = VW'(len_q) + VW'(NUM_DIGITS);

    ascii_msg_buffer #(
        .MSG_DEPTH  (MSG_DEPTH),
        .NUM_DIGITS (NUM_DIGITS),
        .AW         (AW)
    ) u_buf (
        .clk     (clk),
        .we_i    (accept),
        .waddr_i (AW'(len_q)),
        .wdata_i (wr_char),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    // Virtual index: NUM_DIGITS leading blanks, then the message.
    always_comb begin
        raddr = '0;
        blank = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            vsum[d]  = off_q + VW'(d);
            vidx[d]  = (vsum[d] >= plen) ? vsum[d] - plen : vsum[d];
            blank[d] = vidx[d] < VW'(NUM_DIGITS);
            raddr[d] = AW'(vidx[d] - VW'(NUM_DIGITS));
        end
    end

    always_comb begin
        ascii_d = {NUM_DIGITS{ASCII_SPACE}};
        if (!clear && state_q == SCROLL) begin
            for (int d = 0; d < NUM_DIGITS; d++) begin
                ascii_d[8*(NUM_DIGITS-d)-1 -: 8] =
                    blank[d] ? ASCII_SPACE : rdata[d];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        off_d   = off_q;
        tick_d  = tick_q;
        if (clear) begin
            state_d = IDLE;
            len_d   = '0;
            off_d   = '0;
            tick_d  = '0;
        end else begin
            unique case (state_q)
                IDLE, LOAD: begin
                    if (accept) begin
                        len_d   = len_q + LW'(1);
                        state_d = commit ? SCROLL : LOAD;
                        off_d   = '0;
                        tick_d  = '0;
                    end
                end
                SCROLL: begin
                    if (run) begin
                        if (last_tick) begin
                            tick_d = '0;
                            off_d  = (off_q == plen - VW'(1))
                                     ? '0 : off_q + VW'(1);
                        end else begin
                            tick_d = tick_q + TW'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            off_q   <= '0;
            tick_q  <= '0;
            ascii_q <= {NUM_DIGITS{ASCII_SPACE}};
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            off_q   <= off_d;
            tick_q  <= tick_d;
            ascii_q <= ascii_d;
        end
    end

    assign ascii_out = ascii_q;
    assign msg_len   = len_q;
    assign scrolling = (state_q == SCROLL);

endmodule

// File: tb/tb_ascii_scroller.sv
// Scoreboard bench for ascii_scroller (NUM_DIGITS=4, MSG_DEPTH=8,
// TICK_DIV=4); build with ASCII_SCROLLER_HOLD_EN to cover hold.
module tb_ascii_scroller;

    localparam int ND  = 4;
    localparam int DEP = 8;
    localparam int TD  = 4;
    localparam int LW  = $clog2(DEP + 1);
    localparam logic [8*ND-1:0] SP = {ND{8'h20}};
`ifdef ASCII_SCROLLER_HOLD_EN
    localparam bit HOLD_EN = 1'b1;
`else
    localparam bit HOLD_EN = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst_n    = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_char  = 8'h00;
    logic          wr_last  = 1'b0;
    logic          clear    = 1'b0;
`ifdef ASCII_SCROLLER_HOLD_EN
    logic          hold     = 1'b0;
`endif
    logic          wr_ready;
    logic          scrolling;
    logic [8*ND-1:0] ascii_out;
    logic [LW-1:0] msg_len;

    always #5 clk = ~clk;

    ascii_scroller #(
        .NUM_DIGITS (ND),
        .MSG_DEPTH  (DEP),
        .TICK_DIV   (TD)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_char   (wr_char),
        .wr_last   (wr_last),
        .clear     (clear),
`ifdef ASCII_SCROLLER_HOLD_EN
        .hold      (hold),
`endif
        .ascii_out (ascii_out),
        .msg_len   (msg_len),
        .scrolling (scrolling)
    );

    typedef struct {
        logic [8*ND-1:0] a;
        int              len;
        bit              scr;
    } exp_t;

    exp_t q[$];
    int vecs = 0;
    int errs = 0;

    // Reference model: message text, mode (0 idle, 1 load, 2 scroll)
    // and the number of un-held cycles spent scrolling.
    byte unsigned msg[$];
    int mode = 0;
    int sc   = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic int cur_off();
        return (sc / TD) % (msg.size() + ND);
    endfunction

    function automatic logic [8*ND-1:0] disp(input int o);
        logic [8*ND-1:0] r;
        int p;
        int v;
        r = SP;
        p = msg.size() + ND;
        for (int d = 0; d < ND; d++) begin
            v = (o + d) % p;
            r[8*(ND-d)-1 -: 8] = (v < ND) ? 8'h20 : msg[v-ND];
        end
        return r;
    endfunction

    task automatic step(input bit v, input logic [7:0] ch,
                        input bit last, input bit clr, input bit hld);
        exp_t e;
        @(negedge clk);
        wr_valid = v;
        wr_char  = ch;
        wr_last  = last;
        clear    = clr;
`ifdef ASCII_SCROLLER_HOLD_EN
        hold     = hld;
`endif
        #1;
        chk("wr_ready", wr_ready,
            (!clr && mode != 2 && msg.size() < DEP));
        e.a = (mode == 2 && !clr) ? disp(cur_off()) : SP;
        if (clr) begin
            mode = 0;
            msg.delete();
            sc = 0;
        end else if (mode == 2) begin
            if (!hld) sc++;
        end else if (v && msg.size() < DEP) begin
            msg.push_back(ch);
            if (last || msg.size() == DEP) begin
                mode = 2;
                sc   = 0;
            end else begin
                mode = 1;
            end
        end
        e.len = msg.size();
        e.scr = (mode == 2);
        q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic run_to_off(input int o);
        for (int i = 0; i < 200; i++) begin
            if (cur_off() == o) return;
            idle(1);
        end
        chk("reach_offset", 64'(cur_off()), 64'(o));
    endtask

    // Monitor: one expected record per clock edge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("ascii_out", ascii_out, e.a);
            chk("msg_len", 64'(msg_len), 64'(e.len));
            chk("scrolling", scrolling, e.scr);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_ascii", ascii_out, SP);
        chk("rst_ready", wr_ready, 1'b1);
        chk("rst_scroll", scrolling, 1'b0);
        chk("rst_len", 64'(msg_len), 64'd0);

        // "HI": period 6, one full wrap
        step(1'b1, 8'h48, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h49, 1'b1, 1'b0, 1'b0);
        idle(7 * TD + 2);

        // Clear at offset 3, then reload "A"
        run_to_off(3);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        idle(2 * TD + 2);

        // Fill to depth without wr_last, then a 9th write
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEP; i++)
            step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h39, 1'b1, 1'b0, 1'b0);
        idle(3 * TD);

        // Clear and write together during LOAD
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h56, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Asynchronous reset mid-scroll
        step(1'b1, 8'h57, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h58, 1'b1, 1'b0, 1'b0);
        idle(2 * TD + 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_ascii", ascii_out, SP);
        chk("arst_ready", wr_ready, 1'b1);
        chk("arst_scroll", scrolling, 1'b0);
        chk("arst_len", 64'(msg_len), 64'd0);
        mode = 0;
        msg.delete();
        sc = 0;
        wr_valid = 1'b0;
        wr_last  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        if (HOLD_EN) begin
            step(1'b1, 8'h48, 1'b0, 1'b0, 1'b0);
            step(1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
            step(1'b1, 8'h4c, 1'b1, 1'b0, 1'b0);
            run_to_off(2);
            idle(1);
            for (int i = 0; i < 10; i++)
                step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
            idle(2 * TD + 1);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
            step(1'b1, 8'h5a, 1'b1, 1'b0, 1'b1);
            idle(TD + 2);
            step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        end

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            step(1'($urandom_range(0, 1)),
                 8'($urandom_range(0, 255)),
                 $urandom_range(0, 5) == 0,
                 $urandom_range(0, 39) == 0,
                 HOLD_EN && ($urandom_range(0, 3) == 0));
        end

        idle(2);
        @(posedge clk);
        #2;
        chk("queue_drain", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/ascii_scroller.md
# ascii_scroller

Message buffer and scroll sequencer that sits directly upstream of the per-digit ASCII-to-7-segment decoders. A host loads an ASCII string one character at a time. The block then scrolls that string right-to-left across NUM_DIGITS displays at a fixed tick rate, wrapping indefinitely. It presents one 8-bit ASCII code per digit, and each code feeds one decoder instance. Blank positions carry ASCII space (8'h20), which the decoders render as all segments off.

## Interface
- NUM_DIGITS, 6: number of display digits driven.
- MSG_DEPTH, 32: maximum message length in characters.
- TICK_DIV, 25_000_000: clock cycles per scroll step (≥2).
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- wr_valid  in  1  character write request.
- wr_ready  out  1  block can accept a character this cycle.
- wr_char  in  8  ASCII character to append.
- wr_last  in  1  qualifies wr_char as the final character of the message.
- clear  in  1  synchronous flush back to empty/idle.
- hold  in  1  freezes scrolling; present only with ASCII_SCROLLER_HOLD_EN.
- ascii_out  out  8*NUM_DIGITS  digit codes; the leftmost digit is at [8*NUM_DIGITS-1 -: 8].
- msg_len  out  $clog2(MSG_DEPTH+1)  number of committed or loading characters.
- scrolling  out  1  high in the SCROLL state.

## Operation
- There are three states: IDLE (empty), LOAD (at least one character written, not yet committed) and SCROLL.
- wr_ready = !clear && state != SCROLL && msg_len < MSG_DEPTH. A write is accepted when wr_valid && wr_ready.
- An accepted write stores wr_char at index msg_len and increments msg_len. IDLE moves to LOAD on the first accepted write.
- An accepted write with wr_last=1, or the write that brings msg_len to MSG_DEPTH, moves the block to SCROLL (from IDLE or LOAD). A one-character message is legal.
- In SCROLL, wr_ready=0. Writes are ignored until clear is asserted.
- Virtual sequence: NUM_DIGITS spaces followed by msg[0..L-1], total period P = L + NUM_DIGITS.
- Digit d (0 = leftmost) shows virtual[(offset + d) mod P]. Index v < NUM_DIGITS gives 8'h20; otherwise it gives msg[v-NUM_DIGITS].
- Tick counter: counts 0..TICK_DIV-1 only in SCROLL. At TICK_DIV-1 it returns to 0 and offset advances. At offset = P-1 the advance wraps offset to 0.
- Entering SCROLL sets offset=0 and the tick counter to 0.
- In IDLE and LOAD, ascii_out is all spaces.
- clear has priority over everything. The next state is IDLE with msg_len=0, offset=0 and tick=0. Buffer contents become don't-care.
- Reset values: state IDLE, msg_len 0, offset 0, tick 0, ascii_out all 8'h20, wr_ready 1, scrolling 0.

## Timing
- Write accepted at edge t: msg_len updates at t+1. When the write commits, scrolling=1 at t+1.
- ascii_out is registered and reflects offset with 1 cycle latency. After commit at t, ascii_out stays all spaces through t+1.
- First offset advance at t+TICK_DIV. The new ascii_out appears at t+TICK_DIV+1.
- Clear asserted at edge t: wr_ready is 0 combinationally during that cycle. State is IDLE and ascii_out is all spaces at t+1, and wr_ready=1 at t+1.
- wr_valid and clear in the same cycle: the character is dropped.
- rst_n deasserted mid-load or mid-scroll: all state returns to reset values immediately (asynchronous). Recovery is on the first clk edge after release.

## Configuration
- ASCII_SCROLLER_HOLD_EN defined:
  - The hold port exists.
  - hold=1 in SCROLL freezes both the tick counter and offset. ascii_out stays stable.
  - hold has no effect on loading or clear; clear still flushes while hold=1.
- Macro undefined: no hold port, and scrolling never pauses.

## Structure
- Shared package ascii_disp_pkg:
  - ASCII_SPACE = 8'h20.
  - State enum scroll_state_t {IDLE, LOAD, SCROLL}.
  - Default NUM_DIGITS.
- Sub-module ascii_msg_buffer: MSG_DEPTH×8 register array with a write port (index, data, enable) and NUM_DIGITS combinational read ports. The top level holds the FSM, counters and the virtual-index/blank mapping.

## Test plan
Benches run with NUM_DIGITS=4, MSG_DEPTH=8, TICK_DIV=4.
- Reset -> ascii_out=32'h20202020, wr_ready=1, scrolling=0, msg_len=0.
- Load 8'h48, then 8'h49 with wr_last -> scrolling=1, msg_len=2, P=6. On successive advances ascii_out = 20202048, 20204849, 20484920, 48492020, 49202020, then wraps to 20202020.
- Write 8 characters with no wr_last -> wr_ready=0 after the 8th, scrolling=1. A 9th wr_valid is ignored and msg_len stays 8.
- clear asserted during SCROLL at offset 3 -> next cycle ascii_out=20202020, msg_len=0, wr_ready=1. Reloading "A" gives 20202041 at the first advance.
- clear and wr_valid in the same cycle during LOAD -> character dropped, IDLE, msg_len=0. rst_n pulsed mid-scroll -> reset values asynchronously.
- With ASCII_SCROLLER_HOLD_EN: hold=1 for 10 cycles at offset 2 -> ascii_out constant, and the next advance occurs exactly the remaining tick count after hold drops.
